// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage definitions: boot address, NOP encoding, FSM states and PC helpers.
package fetch_stage_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h4000_0000;
  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;  // addi x0,x0,0

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  // Modulo-2**32 increment; 32'hFFFF_FFFC wraps to 0.
  function automatic logic [31:0] pc_next(input logic [31:0] addr);
    return addr + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, drives the sync-read IMEM and presents {inst, pc} to decode,
// with boot sequencing, stall hold and zero-bubble redirect that squashes the wrong-path slot.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          IMEM_AW  = 14,
  parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic               imem_en,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_dout,
  output logic [31:0]        inst,
  output logic [31:0]        pc,
  output logic               inst_valid
);

  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  dec_pc_q, dec_pc_d;
  logic [31:0]  req_pc;
  logic         advance;
  logic [1:0]   unused_redirect_lsb;

  assign unused_redirect_lsb = redirect_pc[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= BOOT;
      fetch_pc_q <= RESET_PC;
      dec_pc_q   <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      dec_pc_q   <= dec_pc_d;
    end
  end

  // dec_pc always names the word the IMEM was asked for, so it tracks req_pc on every advance,
  // including a redirect arriving during BOOT.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    dec_pc_d   = dec_pc_q;
    req_pc     = redirect_valid ? word_align(redirect_pc) : fetch_pc_q;
    advance    = (state_q == BOOT) | redirect_valid | ~stall;

    if (advance) begin
      state_d    = RUN;
      fetch_pc_d = pc_next(req_pc);
      dec_pc_d   = req_pc;
    end
  end

  // Holding imem_en low on stall freezes the IMEM output register, which keeps inst stable.
  always_comb begin
    imem_en    = advance;
    imem_addr  = req_pc[IMEM_AW+1:2];
    pc         = dec_pc_q;
    inst_valid = (state_q == RUN) & ~redirect_valid;
    inst       = inst_valid ? imem_dout : NOP_INST;
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: boot, stall hold, redirect squash, redirect-over-stall,
// back-to-back redirects, PC wrap and asynchronous mid-run reset.
module tb_fetch_stage;

  localparam int          AW  = 14;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          rst;
  logic          stall;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          imem_en;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_dout;
  logic [31:0]   inst;
  logic [31:0]   pc;
  logic          inst_valid;

  int vectors = 0;
  int errs    = 0;

  fetch_stage #(
    .RESET_PC(32'h4000_0000),
    .IMEM_AW (AW),
    .NOP_INST(NOP)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_en       (imem_en),
    .imem_addr     (imem_addr),
    .imem_dout     (imem_dout),
    .inst          (inst),
    .pc            (pc),
    .inst_valid    (inst_valid)
  );

  always #5 clk = ~clk;

  // IMEM: word w holds 32'hC0DE_0000 | w; output register holds while en is low.
  initial imem_dout = 32'h0;
  always @(posedge clk) begin
    if (imem_en) imem_dout <= 32'hC0DE_0000 | {18'b0, imem_addr};
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish within 100000 time units");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic cyc(input logic s, input logic rv, input logic [31:0] rpc);
    @(negedge clk);
    stall          = s;
    redirect_valid = rv;
    redirect_pc    = rpc;
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] e_pc, input logic [31:0] e_inst,
                         input logic e_vld);
    chk({tag, ".pc"}, pc, e_pc);
    chk({tag, ".inst"}, inst, e_inst);
    chk({tag, ".vld"}, {31'b0, inst_valid}, {31'b0, e_vld});
  endtask

  initial begin
    rst            = 1'b1;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    chk_out("reset", 32'h4000_0000, NOP, 1'b0);

    // Test 1: boot then sequential fetch
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_out("boot", 32'h4000_0000, NOP, 1'b0);
    chk("boot.en", {31'b0, imem_en}, 32'd1);
    chk("boot.addr", {18'b0, imem_addr}, 32'h0);
    cyc(1'b0, 1'b0, 32'h0);
    chk_out("seq0", 32'h4000_0000, 32'hC0DE_0000, 1'b1);
    chk("seq0.addr", {18'b0, imem_addr}, 32'h1);
    cyc(1'b0, 1'b0, 32'h0);
    chk_out("seq1", 32'h4000_0004, 32'hC0DE_0001, 1'b1);
    cyc(1'b0, 1'b0, 32'h0);
    chk_out("seq2", 32'h4000_0008, 32'hC0DE_0002, 1'b1);

    // Test 2: stall three cycles at 4000_0008 (stall asserted in the seq2 cycle)
    stall = 1'b1;
    #1;
    chk("stall0.en", {31'b0, imem_en}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, 1'b0, 32'h0);
      chk_out("stallN", 32'h4000_0008, 32'hC0DE_0002, 1'b1);
      chk("stallN.en", {31'b0, imem_en}, 32'd0);
    end
    cyc(1'b0, 1'b0, 32'h0);
    chk_out("release", 32'h4000_0008, 32'hC0DE_0002, 1'b1);
    cyc(1'b0, 1'b0, 32'h0);
    chk_out("post_stall", 32'h4000_000C, 32'hC0DE_0003, 1'b1);

    // Test 3: redirect to 4000_0100 while pc=4000_0010
    cyc(1'b0, 1'b1, 32'h4000_0100);
    chk_out("redir", 32'h4000_0010, NOP, 1'b0);
    chk("redir.addr", {18'b0, imem_addr}, 32'h40);
    cyc(1'b0, 1'b0, 32'h0);
    chk_out("redir_tgt", 32'h4000_0100, 32'hC0DE_0040, 1'b1);

    // Test 4: stall and redirect together; redirect wins, low bits dropped
    cyc(1'b1, 1'b1, 32'h4000_0203);
    chk("rs.en", {31'b0, imem_en}, 32'd1);
    chk("rs.addr", {18'b0, imem_addr}, 32'h80);
    chk("rs.vld", {31'b0, inst_valid}, 32'd0);
    cyc(1'b0, 1'b0, 32'h0);
    chk_out("rs_tgt", 32'h4000_0200, 32'hC0DE_0080, 1'b1);

    // Test 5: back-to-back redirects, last one wins
    cyc(1'b0, 1'b1, 32'h4000_0040);
    chk("bb1.vld", {31'b0, inst_valid}, 32'd0);
    chk("bb1.addr", {18'b0, imem_addr}, 32'h10);
    cyc(1'b0, 1'b1, 32'h4000_0080);
    chk_out("bb2", 32'h4000_0040, NOP, 1'b0);
    chk("bb2.addr", {18'b0, imem_addr}, 32'h20);
    cyc(1'b0, 1'b0, 32'h0);
    chk_out("bb_tgt", 32'h4000_0080, 32'hC0DE_0020, 1'b1);

    // PC wrap: FFFF_FFFC + 4 -> 0, and word address aliases to low bits
    cyc(1'b0, 1'b1, 32'hFFFF_FFFC);
    chk("wrap.addr", {18'b0, imem_addr}, 32'h3FFF);
    cyc(1'b0, 1'b0, 32'h0);
    chk_out("wrap", 32'hFFFF_FFFC, 32'hC0DE_3FFF, 1'b1);
    chk("wrap.next", {18'b0, imem_addr}, 32'h0);
    cyc(1'b0, 1'b0, 32'h0);
    chk_out("wrap0", 32'h0000_0000, 32'hC0DE_0000, 1'b1);

    // Test 6: asynchronous reset pulse between clock edges
    cyc(1'b0, 1'b0, 32'h0);
    #2;
    rst = 1'b1;
    #1;
    chk_out("arst", 32'h4000_0000, NOP, 1'b0);
    @(negedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk_out("reboot", 32'h4000_0000, NOP, 1'b0);
    chk("reboot.addr", {18'b0, imem_addr}, 32'h0);
    cyc(1'b0, 1'b0, 32'h0);
    chk_out("rseq0", 32'h4000_0000, 32'hC0DE_0000, 1'b1);
    cyc(1'b0, 1'b0, 32'h0);
    chk_out("rseq1", 32'h4000_0004, 32'hC0DE_0001, 1'b1);
    cyc(1'b0, 1'b0, 32'h0);
    chk_out("rseq2", 32'h4000_0008, 32'hC0DE_0002, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
